uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Front-end command stage between the UART receiver and the watch mode/time control FSMs. It takes raw bytes from the UART RX, normalises and filters them into one-cycle command strobes on `pc_data`, the bus the mode FSMs compare against ASCII codes. It also echoes every received byte back through the UART TX via a small FIFO and handshake FSM.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: echo FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-low; sampled on rising `clk`
- `rx_data`  in  8  byte from UART RX; valid only while `rx_done`=1
- `rx_done`  in  1  one-cycle strobe, byte received
- `tx_busy`  in  1  UART TX busy; high from the cycle after `tx_start` until the stop bit ends
- `pc_data`  out  8  command byte, valid for exactly one cycle; 8'h00 otherwise
- `cmd_valid`  out  1  high in the same cycle that `pc_data` is non-zero
- `tx_data`  out  8  echo byte; held stable from `tx_start` until the FSM returns to IDLE
- `tx_start`  out  1  one-cycle TX start pulse
- `err_overflow`  out  1  sticky flag, set when an echo byte is dropped

## Operation
- Case folding: `rx_data` in 8'h61–8'h7A has 8'h20 subtracted before matching.
- Accepted command set after folding: 'M' 8'h4D (mode), 'H' 8'h48 (hour/min view), 'R' 8'h52 (run/stop), 'C' 8'h43 (clear), 'U' 8'h55 (up), 'D' 8'h44 (down), 'L' 8'h4C (left/select).
- On an accepted byte, `pc_data` is the folded code and `cmd_valid`=1 for one cycle.
- All other bytes, including CR 8'h0D, LF 8'h0A, and 8'h00, produce no strobe. `pc_data` stays 8'h00.
- Echo path: every received byte is pushed unfolded and unfiltered into the echo FIFO.
- Echo FSM states:
  - IDLE: FIFO non-empty → pop the head into `tx_data`, go to START.
  - START: `tx_start`=1 for one cycle → go to WAIT_BUSY.
  - WAIT_BUSY: `tx_busy`=1 → go to WAIT_DONE. After 15 cycles without busy → go to IDLE. A byte lost this way is not re-sent and does not set `err_overflow`.
  - WAIT_DONE: `tx_busy`=0 → go to IDLE.
- FIFO full:
  - A push without a simultaneous pop is dropped and sets `err_overflow`.
  - A push with a simultaneous pop succeeds.
  - `err_overflow` clears only on reset.
- Pop on empty FIFO cannot occur; IDLE pops only when the FIFO is non-empty.

## Timing
- Reset values: `pc_data`=8'h00, `cmd_valid`=0, `tx_data`=8'h00, `tx_start`=0, `err_overflow`=0. FIFO is empty and the FSM is in IDLE.
- Command latency: `rx_done` at rising edge N → `pc_data`/`cmd_valid` registered, visible after edge N+1, cleared after edge N+2.
- Back-to-back `rx_done` on consecutive cycles produces consecutive strobes; none are merged or lost.
- Echo latency with the FSM idle: push at N+1, pop/IDLE→START at N+2, `tx_start` high after edge N+3.
- Minimum spacing between successive `tx_start` pulses is 4 cycles (IDLE→START→WAIT_BUSY→WAIT_DONE→IDLE).
- Reset mid-operation:
  - Reset asserted during WAIT_BUSY/WAIT_DONE forces IDLE, empties the FIFO, and clears `tx_start` on the next edge.
  - An `rx_done` in the same cycle as reset is ignored.

## Configuration
- Macro: `UART_CMD_ECHO_EN`.
- Defined: the echo FIFO and echo FSM are built as described above.
- Undefined:
  - FIFO and FSM are absent.
  - `tx_data`=8'h00, `tx_start`=0, and `err_overflow`=0 constantly.
  - `tx_busy` is ignored.
  - The command path is unchanged.

## Structure
- Shared package `cmd_pkg`:
  - ASCII command constants `CMD_MODE`, `CMD_HOUR`, `CMD_RUN`, `CMD_CLEAR`, `CMD_UP`, `CMD_DOWN`, `CMD_LEFT`.
  - Echo FSM state encoding `ECHO_IDLE/START/WAIT_BUSY/WAIT_DONE`.
  - Timeout constant `ECHO_TIMEOUT`=15.
- One sub-module: `cmd_echo_fifo`, a synchronous FIFO with the `FIFO_DEPTH` parameter, push/pop, full/empty, and simultaneous push+pop when full.

## Test plan
- Send 'm' (8'h6D) with `rx_done` at cycle 10 → `pc_data`=8'h4D and `cmd_valid`=1 only in cycle 11; 8'h00 before and after.
- Send 'x', 8'h0D, 'H' on consecutive cycles → a single strobe 8'h48, two cycles after the 'x' strobe; three bytes echoed in order 8'h78, 8'h0D, 8'h48.
- Hold `tx_busy` high for 100 cycles after each `tx_start` and push 6 bytes rapidly → first 5 accepted (1 in TX plus 4 in FIFO), 6th dropped, `err_overflow`=1 and sticky.
- `tx_busy` never rises after `tx_start` → FSM returns to IDLE 15 cycles later and the next FIFO byte starts.
- Assert `rst`=0 during WAIT_DONE with 3 bytes queued → all outputs take their reset values next edge; no further `tx_start` pulses.
- Build without `UART_CMD_ECHO_EN` and send 'R' → `pc_data`=8'h52 strobe; `tx_start` never asserts.

Source files
------------

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared command codes, echo FSM encoding and timeout for uart_cmd_decoder
// Contents:
//   CMD_*         ASCII command codes the mode FSMs compare against pc_data
//   echo_state_t  echo FSM state encoding
//   ECHO_TIMEOUT  cycles the echo FSM waits for tx_busy before giving up
//   is_cmd()      true for a folded byte in the accepted command set
package cmd_pkg;
    localparam logic [7:0] CMD_MODE  = 8'h4D;
    localparam logic [7:0] CMD_HOUR  = 8'h48;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_CLEAR = 8'h43;
    localparam logic [7:0] CMD_UP    = 8'h55;
    localparam logic [7:0] CMD_DOWN  = 8'h44;
    localparam logic [7:0] CMD_LEFT  = 8'h4C;
    localparam int ECHO_TIMEOUT = 15;
    typedef enum logic [1:0] {
        ECHO_IDLE,
        ECHO_START,
        ECHO_WAIT_BUSY,
        ECHO_WAIT_DONE
    } echo_state_t;
    function automatic logic is_cmd(input logic [7:0] c);
        return c inside {CMD_MODE, CMD_HOUR, CMD_RUN, CMD_CLEAR, CMD_UP, CMD_DOWN, CMD_LEFT};
    endfunction
endpackage

// File: rtl/cmd_echo_fifo.sv
// cmd_echo_fifo: synchronous byte FIFO buffering echo bytes for the UART TX
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   push, din  write request and byte; accepted when not full or when popping
//   pop        read request; advances the head (never issued when empty)
//   dout       current head byte (valid while not empty)
//   full,empty occupancy flags
module cmd_echo_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts push+pop
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: folds/filters UART RX bytes into command strobes and echoes every byte to UART TX
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   rx_data, rx_done  received byte and its one-cycle strobe
//   tx_busy           UART TX busy
//   pc_data           accepted command code for one cycle, else 8'h00
//   cmd_valid         high with a non-zero pc_data
//   tx_data, tx_start echo byte and one-cycle TX start pulse
//   err_overflow      sticky: an echo byte was dropped on a full FIFO
// Build option: define UART_CMD_ECHO_EN to include the echo FIFO and echo FSM;
// without it the TX outputs are tied to zero and tx_busy is ignored.
module uart_cmd_decoder
    import cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic [7:0] pc_data,
    output logic       cmd_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       err_overflow
);
    logic [7:0] folded;
    logic       accept;
    assign folded = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 : rx_data;
    assign accept = rx_done && is_cmd(folded);
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_data   <= 8'h00;
            cmd_valid <= 1'b0;
        end else begin
            pc_data   <= accept ? folded : 8'h00;
            cmd_valid <= accept;
        end
    end
`ifdef UART_CMD_ECHO_EN
    echo_state_t state, next_state;
    logic [3:0] wait_cnt;
    logic [7:0] head;
    logic       full, empty, pop;
    assign pop = state == ECHO_IDLE && !empty;
    cmd_echo_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_done),
        .pop   (pop),
        .din   (rx_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        next_state = state;
        case (state)
            ECHO_IDLE:      next_state = empty ? ECHO_IDLE : ECHO_START;
            ECHO_START:     next_state = ECHO_WAIT_BUSY;
            // give up on a TX that never reports busy; that byte is not retried
            ECHO_WAIT_BUSY: next_state = tx_busy ? ECHO_WAIT_DONE :
                                         wait_cnt == 4'(ECHO_TIMEOUT - 1) ? ECHO_IDLE : ECHO_WAIT_BUSY;
            ECHO_WAIT_DONE: next_state = tx_busy ? ECHO_WAIT_DONE : ECHO_IDLE;
            default:        next_state = ECHO_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ECHO_IDLE;
            wait_cnt     <= '0;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= state == ECHO_WAIT_BUSY ? wait_cnt + 4'd1 : 4'd0;
            tx_start <= state == ECHO_START;
            if (pop) tx_data <= head;
            if (rx_done && full && !pop) err_overflow <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg   = tx_busy ^ FIFO_DEPTH[0];
    assign tx_data      = 8'h00;
    assign tx_start     = 1'b0;
    assign err_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed + randomized self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] pc_data;
    logic       cmd_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       err_overflow;

    uart_cmd_decoder #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .tx_busy      (tx_busy),
        .pc_data      (pc_data),
        .cmd_valid    (cmd_valid),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int busy_len = 3;
    int busy_cnt = 0;
    int bad_tx = 0;
    logic [7:0] echo_q[$];
    int         echo_t[$];
    logic [7:0] sent_q[$];

    // UART TX stand-in: logs each started byte, then reports busy for busy_len cycles
    always begin
        @(posedge clk);
        #2;
        if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            tx_busy = 1'b0;
        end
        if (tx_start === 1'b1) begin
            echo_q.push_back(tx_data);
            echo_t.push_back(cyc);
            busy_cnt = busy_len;
        end
        if (tx_start !== 1'b1 && tx_start !== 1'b0) bad_tx++;
`ifndef UART_CMD_ECHO_EN
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || err_overflow !== 1'b0) bad_tx++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: ASCII lower case maps to upper case; only the seven letters MHRCUDL strobe
    function automatic logic [7:0] exp_cmd(input logic [7:0] b);
        string cmds = "MHRCUDL";
        logic [7:0] up;
        up = (b >= "a" && b <= "z") ? b - 8'd32 : b;
        for (int i = 0; i < cmds.len(); i++)
            if (cmds[i] == up) return up;
        return 8'h00;
    endfunction

    function automatic logic [7:0] pick_byte();
        string pool = "mhrcudlMHRCUDLxz";
        logic [7:0] r;
        if ($urandom_range(0, 1) == 0) begin
            r = pool[$urandom_range(0, pool.len() - 1)];
            return r;
        end
        r = 8'($urandom);
        return r;
    endfunction

    int last_rx_cyc = 0;

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        last_rx_cyc = cyc;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic check_cmd(input logic [7:0] b);
        logic [7:0] e;
        e = exp_cmd(b);
        check("pc_data", 32'(pc_data), 32'(e));
        check("cmd_valid", 32'(cmd_valid), 32'(e != 8'h00));
    endtask

    task automatic check_quiet();
        check("pc_data_idle", 32'(pc_data), 32'h0);
        check("cmd_valid_idle", 32'(cmd_valid), 32'h0);
    endtask

    task automatic wait_echo(input int n, input int limit);
        int k;
        k = 0;
        while (echo_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        if (echo_q.size() < n) check("echo_wait_timeout", 32'(echo_q.size()), 32'(n));
    endtask

    initial begin
        logic [7:0] b;
        int t_first;
        int sz;
        logic [7:0] burst[6];

        // reset, with an rx_done that must be ignored
        rst = 1'b0;
        rx_data = "M";
        rx_done = 1'b1;
        repeat (3) tick();
        check("rst_pc_data", 32'(pc_data), 32'h0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_err", 32'(err_overflow), 32'h0);
        rst = 1'b1;
        rx_done = 1'b0;
        tick();
        check_quiet();
        repeat (10) tick();
        check("rst_rx_not_echoed", 32'(echo_q.size()), 32'h0);

        // single lower-case command
        check_quiet();
        send("m");
        t_first = last_rx_cyc;
        check_cmd("m");
        tick();
        check_quiet();

        // 'x', CR, 'H' back to back: only H strobes, two cycles after x's slot
        send("x");
        check_cmd("x");
        send(8'h0D);
        check_cmd(8'h0D);
        send("H");
        check_cmd("H");
        tick();
        check_quiet();
`ifdef UART_CMD_ECHO_EN
        wait_echo(4, 100);
        check("echo_latency", 32'(echo_t[0] - t_first), 32'd2);
        if (echo_q.size() >= 4) begin
            check("echo0", 32'(echo_q[0]), 32'h6D);
            check("echo1", 32'(echo_q[1]), 32'h78);
            check("echo2", 32'(echo_q[2]), 32'h0D);
            check("echo3", 32'(echo_q[3]), 32'h48);
        end
        repeat (20) tick();
`endif

        // randomized commands with occasional back-to-back pairs
        echo_q.delete();
        echo_t.delete();
        sent_q.delete();
        for (int i = 0; i < 30; i++) begin
            b = pick_byte();
            send(b);
            check_cmd(b);
            sent_q.push_back(b);
            if ($urandom_range(0, 3) == 0) begin
                b = pick_byte();
                send(b);
                check_cmd(b);
                sent_q.push_back(b);
            end
            tick();
            check_quiet();
            repeat ($urandom_range(16, 20)) tick();
        end
`ifdef UART_CMD_ECHO_EN
        wait_echo(sent_q.size(), 200);
        check("rand_echo_count", 32'(echo_q.size()), 32'(sent_q.size()));
        for (int i = 0; i < sent_q.size() && i < echo_q.size(); i++)
            check($sformatf("rand_echo%0d", i), 32'(echo_q[i]), 32'(sent_q[i]));
        check("rand_no_overflow", 32'(err_overflow), 32'h0);

        // overflow: long busy, six bytes back to back -> 1 in TX + 4 queued, 6th dropped
        repeat (20) tick();
        busy_len = 100;
        echo_q.delete();
        echo_t.delete();
        for (int i = 0; i < 6; i++) begin
            burst[i] = 8'h30 + 8'(i);
            send(burst[i]);
        end
        tick();
        check("ovf_set", 32'(err_overflow), 32'h1);
        wait_echo(5, 1000);
        repeat (250) tick();
        check("ovf_echo_count", 32'(echo_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < echo_q.size(); i++)
            check($sformatf("ovf_echo%0d", i), 32'(echo_q[i]), 32'(burst[i]));
        check("ovf_sticky", 32'(err_overflow), 32'h1);

        // TX never reports busy: 15-cycle timeout, then the next byte starts
        busy_len = 0;
        busy_cnt = 0;
        repeat (5) tick();
        echo_q.delete();
        echo_t.delete();
        send("A");
        t_first = last_rx_cyc;
        send("B");
        wait_echo(2, 200);
        if (echo_q.size() >= 2) begin
            check("to_latency", 32'(echo_t[0] - t_first), 32'd2);
            check("to_spacing", 32'(echo_t[1] - echo_t[0]), 32'd17);
            check("to_echo0", 32'(echo_q[0]), 32'h41);
            check("to_echo1", 32'(echo_q[1]), 32'h42);
        end
        repeat (40) tick();

        // reset during WAIT_DONE with three bytes still queued
        busy_len = 100;
        echo_q.delete();
        echo_t.delete();
        send("1");
        send("2");
        send("3");
        send("4");
        wait_echo(1, 50);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_pc_data", 32'(pc_data), 32'h0);
        check("mid_rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h0);
        check("mid_rst_tx_start", 32'(tx_start), 32'h0);
        check("mid_rst_err", 32'(err_overflow), 32'h0);
        rst = 1'b1;
        busy_len = 0;
        busy_cnt = 0;
        sz = echo_q.size();
        repeat (40) tick();
        check("mid_rst_no_more_echo", 32'(echo_q.size()), 32'(sz));
`endif

        // 'R' strobes in either build
        send("R");
        check("run_pc_data", 32'(pc_data), 32'h52);
        check("run_cmd_valid", 32'(cmd_valid), 32'h1);
        tick();
        check_quiet();
        repeat (10) tick();
`ifndef UART_CMD_ECHO_EN
        check("noecho_tx_start_count", 32'(echo_q.size()), 32'h0);
`endif
        check("tx_outputs_clean", 32'(bad_tx), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
